// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: state type and width helpers shared by the sequential popcount.
// Also provides the `High/`Low polarity macros used for the ACT parameter.
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

package cnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_seq_state_t;

  function automatic int cnt_out_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int cnt_cw(input int chunk);
    return $clog2(chunk) + 1;
  endfunction

endpackage

// File: rtl/cnt_bits.sv
// cnt_bits: combinational count of the bits of i_data equal to ACT.
// Output is $clog2(IN)+1 bits so an all-active word fits.
`ifndef High
`define High 1'b1
`endif

module cnt_bits
  import cnt_seq_pkg::*;
#(
  parameter int   IN  = 64,
  parameter logic ACT = `High
) (
  input  logic [IN-1:0]         i_data,
  output logic [cnt_cw(IN)-1:0] o_cnt
);

  localparam int CW = cnt_cw(IN);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < IN; i++) begin
      o_cnt = o_cnt + CW'(i_data[i] == ACT);
    end
  end

endmodule

// File: rtl/cnt_bits_seq.sv
// cnt_bits_seq: popcount of a WIDTH-bit word, CHUNK bits per cycle.
// Optional CNT_BITS_SEQ_EARLY_EXIT_EN ends RUN once no active bits remain.
`ifndef High
`define High 1'b1
`endif

module cnt_bits_seq
  import cnt_seq_pkg::*;
#(
  parameter int   WIDTH = 512,
  parameter int   CHUNK = 64,
  parameter logic ACT   = `High
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cnt_out_w(WIDTH)-1:0] out_cnt,
  output logic                        busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int OUT    = cnt_out_w(WIDTH);
  localparam int CW     = cnt_cw(CHUNK);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK < 2) || ((CHUNK & (CHUNK - 1)) != 0) ||
        ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("cnt_bits_seq: CHUNK must be pow2 >= 2 dividing WIDTH");
    end
  endgenerate

  cnt_seq_state_t r_state;
  cnt_seq_state_t w_next;

  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shift;
  logic [OUT-1:0]   r_acc;
  logic [OUT-1:0]   r_cnt;
  logic [OUT-1:0]   w_sum;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    w_part;
  logic             w_last;
  logic             w_accept;

  cnt_bits #(
    .IN  (CHUNK),
    .ACT (ACT)
  ) u_cnt (
    .i_data (r_shreg[CHUNK-1:0]),
    .o_cnt  (w_part)
  );

  assign w_sum    = r_acc + OUT'(w_part);
  assign w_accept = in_valid & in_ready;

  // Shift in the inactive value so spent chunks never count.
  assign w_shift = ACT ? (r_shreg >> CHUNK)
                       : ~((~r_shreg) >> CHUNK);

`ifdef CNT_BITS_SEQ_EARLY_EXIT_EN
  logic [WIDTH-1:0] w_act;
  assign w_act  = ACT ? r_shreg : ~r_shreg;
  assign w_last = (r_idx == IW'(NCHUNK - 1)) ||
                  ~|(w_act >> CHUNK);
`else
  assign w_last = (r_idx == IW'(NCHUNK - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) && !reset;
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= {WIDTH{~ACT}};
      r_acc   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= in_data;
            r_acc   <= '0;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_shreg <= w_shift;
          r_acc   <= w_sum;
          r_idx   <= r_idx + 1'b1;
          if (w_last) r_cnt <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign out_cnt = r_cnt;

endmodule

// File: tb/tb_cnt_bits_seq.sv
// tb_cnt_bits_seq: directed and random checks of cnt_bits_seq.
// Instance 0 counts ones, instance 1 counts zeros.
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module tb_cnt_bits_seq;

  localparam int W  = 512;
  localparam int OW = 10;
`ifdef CNT_BITS_SEQ_EARLY_EXIT_EN
  localparam int EE_LAT = 1;
`else
  localparam int EE_LAT = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          busy      [2];
  logic [W-1:0]  in_data   [2];
  logic [OW-1:0] out_cnt   [2];

  int checks = 0;
  int errors = 0;

  cnt_bits_seq #(.WIDTH(W), .CHUNK(64), .ACT(`High)) u_hi (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_cnt   (out_cnt[0]),
    .busy      (busy[0])
  );

  cnt_bits_seq #(.WIDTH(W), .CHUNK(64), .ACT(`Low)) u_lo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_cnt   (out_cnt[1]),
    .busy      (busy[1])
  );

  // Sends one word, waits for the result, completes the handshake.
  task automatic run_word(input int u, input logic [W-1:0] d,
                          output logic [OW-1:0] cnt,
                          output int lat, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    in_data[u]   = d;
    in_valid[u]  = 1'b1;
    out_ready[u] = 1'b0;
    n = 0;
    while (!in_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[u]) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[u]) ok = 1'b0;
    cnt = out_cnt[u];
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
  endtask

  function automatic logic [W-1:0] gen_word();
    logic [W-1:0] d;
    logic [W-1:0] m;
    int keep;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      keep = $urandom_range(0, 8);
      m = '1;
      m = m >> (64 * (8 - keep));
      if (keep == 0) m = '0;
      d = d & m;
    end
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      in_data[u]   = '0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b out_valid=%b required 0/0",
               busy[0], out_valid[0]);
    end
    checks++;
    if (out_cnt[0] !== 10'd0 || out_cnt[1] !== 10'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d required 0/0",
               out_cnt[0], out_cnt[1]);
    end
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate: in_ready=%b required 0", in_ready[0]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || in_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b/%b required 1/1",
               in_ready[0], in_ready[1]);
    end
  endtask

  task automatic test_high_patterns();
    logic [OW-1:0] c;
    int l;
    bit ok;
    logic [W-1:0] d;
    run_word(0, {W{1'b1}}, c, l, ok);
    checks++;
    if (!ok || c !== 10'd512) begin
      errors++;
      $display("FAIL all_ones: got %0d ok=%0d required 512", c, ok);
    end
    checks++;
    if (l != 8) begin
      errors++;
      $display("FAIL all_ones_latency: got %0d required 8", l);
    end
    d = {128{4'hA}};
    run_word(0, d, c, l, ok);
    checks++;
    if (!ok || c !== 10'd256) begin
      errors++;
      $display("FAIL alt_aaaa: got %0d ok=%0d required 256", c, ok);
    end
    run_word(0, '0, c, l, ok);
    checks++;
    if (!ok || c !== 10'd0) begin
      errors++;
      $display("FAIL all_zero: got %0d ok=%0d required 0", c, ok);
    end
  endtask

  task automatic test_act_low();
    logic [OW-1:0] c;
    int l;
    bit ok;
    logic [W-1:0] d;
    run_word(1, '0, c, l, ok);
    checks++;
    if (!ok || c !== 10'd512) begin
      errors++;
      $display("FAIL low_zero: got %0d ok=%0d required 512", c, ok);
    end
    checks++;
    if (l != 8) begin
      errors++;
      $display("FAIL low_zero_latency: got %0d required 8", l);
    end
    d = {32{16'h00FF}};
    run_word(1, d, c, l, ok);
    checks++;
    if (!ok || c !== 10'd256) begin
      errors++;
      $display("FAIL low_00ff: got %0d ok=%0d required 256", c, ok);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    in_data[0]   = {128{4'hA}};
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data[0] = {W{1'b1}};
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid[0]) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=0 after %0d cycles", n);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || out_cnt[0] !== 10'd256 ||
          in_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b cnt=%0d rdy=%b required 1/256/0",
                 i, out_valid[0], out_cnt[0], in_ready[0]);
      end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
        busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: v=%b rdy=%b busy=%b required 0/1/0",
               out_valid[0], in_ready[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(negedge clk);
    in_data[0]  = {W{1'b1}};
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_busy: busy=%b required 1", busy[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_gate: in_ready=%b required 0", in_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 ||
        out_cnt[0] !== 10'd0) begin
      errors++;
      $display("FAIL mid_run_reset: busy=%b v=%b cnt=%0d required 0/0/0",
               busy[0], out_valid[0], out_cnt[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_release: in_ready=%b required 1", in_ready[0]);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_run_no_result: out_valid seen=1 required 0");
    end
  endtask

  task automatic test_early_exit();
    logic [OW-1:0] c;
    int l;
    bit ok;
    logic [W-1:0] d;
    d = '0;
    d[0] = 1'b1;
    run_word(0, d, c, l, ok);
    checks++;
    if (!ok || c !== 10'd1 || l != EE_LAT) begin
      errors++;
      $display("FAIL ee_bit0: cnt=%0d lat=%0d required 1/%0d", c, l, EE_LAT);
    end
    d = '0;
    d[W-1] = 1'b1;
    run_word(0, d, c, l, ok);
    checks++;
    if (!ok || c !== 10'd1 || l != 8) begin
      errors++;
      $display("FAIL ee_bit511: cnt=%0d lat=%0d required 1/8", c, l);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] q[$];
    logic [OW-1:0] exp_c;
    logic [W-1:0]  cur;
    int sent, recv, cyc;
    bit acc, del;
    sent = 0;
    recv = 0;
    cyc  = 0;
    cur  = gen_word();
    while (recv < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid[0]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data[0]   = cur;
      out_ready[0] = ($urandom_range(0, 2) != 0);
      acc = in_valid[0] && in_ready[0];
      del = out_valid[0] && out_ready[0];
      if (del) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: result %0d with none pending",
                   out_cnt[0]);
        end else begin
          exp_c = q.pop_front();
          if (out_cnt[0] !== exp_c) begin
            errors++;
            $display("FAIL rand_word%0d: got %0d required %0d",
                     recv, out_cnt[0], exp_c);
          end
        end
        recv++;
      end
      if (acc) begin
        q.push_back(OW'($countones(cur)));
        sent++;
        cur = gen_word();
      end
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    checks++;
    if (sent != 1000 || recv != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_stream: sent=%0d recv=%0d pending=%0d required 1000/1000/0",
               sent, recv, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_high_patterns();
    test_act_low();
    test_backpressure();
    test_reset_mid_run();
    test_early_exit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
